// File: rtl/kbd_ctrl_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard event controller.
package kbd_ctrl_pkg;

    typedef logic [7:0] byte_t;

    // One decoded key event: break (release) flag, extended-prefix flag, scancode.
    typedef struct packed {
        logic  brk;
        logic  ext;
        byte_t code;
    } key_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_t;

    localparam byte_t SC_EXT         = 8'hE0;
    localparam byte_t SC_BREAK       = 8'hF0;
    localparam byte_t SC_PAUSE       = 8'hE1;
    localparam byte_t SC_BAT_OK      = 8'hAA;
    localparam byte_t SC_ACK         = 8'hFA;
    localparam byte_t SC_RESEND      = 8'hFE;

    // Keyboard error replies: buffer overrun and self-test failures.
    localparam byte_t SC_ERR_00      = 8'h00;
    localparam byte_t SC_ERR_FF      = 8'hFF;
    localparam byte_t SC_ERR_FC      = 8'hFC;
    localparam byte_t SC_ERR_FD      = 8'hFD;

    // Fake shifts injected around extended keys; they carry no key information.
    localparam byte_t SC_FAKE_LSHIFT = 8'h12;
    localparam byte_t SC_FAKE_RSHIFT = 8'h59;

    // Code reported for the Pause key once its whole sequence has been skipped.
    localparam byte_t SC_PAUSE_CODE  = 8'h77;

    // Bytes following 0xE1 in the Pause make sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/kbd_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded key events.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop on an empty FIFO is ignored; a pop frees the slot a full-FIFO push needs.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);

    // Head entry is read straight from storage; forced to zero while empty.
    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 scancode-set-2 decoder: turns raw keyboard bytes into make/break key
// events, queues them in a FWFT FIFO and tracks keyboard status flags.
module kbd_ctrl
    import kbd_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  byte_t      rx_data_i,
    input  logic       rx_valid_i,
    output key_event_t evt_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic       overflow_o,
    output logic       kbd_err_o,
    output logic       bat_ok_o,
    input  logic       clr_status_i
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int EW = $bits(key_event_t);

    dec_state_t state;
    dec_state_t next_state;
    logic [2:0] skip;
    logic [2:0] next_skip;
    logic [TW-1:0] timer;
    logic       timeout;
    logic       push;
    key_event_t push_evt;
    logic       set_err;
    logic       set_bat;
    logic       fifo_full;
    logic       drop;
    logic [EW-1:0] fifo_out;

    // The timer counts idle cycles inside a sequence; the last allowed one expires it.
    assign timeout = (state != ST_IDLE) && !rx_valid_i && (timer == TW'(TIMEOUT_CYCLES - 1));
    // A full FIFO only drops the event when no pop frees a slot this cycle.
    assign drop    = push && fifo_full && !evt_ready_i;

    // Byte decode: next state, event to push and status flags to raise.
    always_comb begin
        next_state = state;
        next_skip  = skip;
        push       = 1'b0;
        push_evt   = '{brk: 1'b0, ext: 1'b0, code: rx_data_i};
        set_err    = 1'b0;
        set_bat    = 1'b0;
        if (rx_valid_i) begin
            case (state)
                ST_IDLE: begin
                    case (rx_data_i)
                        SC_EXT:    next_state = ST_EXT;
                        SC_BREAK:  next_state = ST_BRK;
                        SC_PAUSE: begin
                            next_state = ST_PAUSE;
                            next_skip  = PAUSE_SKIP;
                        end
                        SC_BAT_OK: set_bat = 1'b1;
                        SC_ERR_00, SC_ERR_FF, SC_ERR_FC, SC_ERR_FD: set_err = 1'b1;
                        SC_ACK, SC_RESEND: ;
                        default:   push = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (rx_data_i == SC_BREAK) begin
                        next_state = ST_EXT_BRK;
                    end else begin
                        next_state = ST_IDLE;
                        push       = (rx_data_i != SC_FAKE_LSHIFT) && (rx_data_i != SC_FAKE_RSHIFT);
                        push_evt   = '{brk: 1'b0, ext: 1'b1, code: rx_data_i};
                    end
                end
                ST_BRK: begin
                    next_state = ST_IDLE;
                    push       = 1'b1;
                    push_evt   = '{brk: 1'b1, ext: 1'b0, code: rx_data_i};
                end
                ST_EXT_BRK: begin
                    next_state = ST_IDLE;
                    push       = (rx_data_i != SC_FAKE_LSHIFT) && (rx_data_i != SC_FAKE_RSHIFT);
                    push_evt   = '{brk: 1'b1, ext: 1'b1, code: rx_data_i};
                end
                ST_PAUSE: begin
                    next_skip = skip - 1'b1;
                    if (skip == 3'd1) begin
                        next_state = ST_IDLE;
                        push       = 1'b1;
                        push_evt   = '{brk: 1'b0, ext: 1'b1, code: SC_PAUSE_CODE};
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end else if (timeout) begin
            next_state = ST_IDLE;
            next_skip  = '0;
        end
    end

    // Decoder state, skip counter and inter-byte timer.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
            skip  <= '0;
            timer <= '0;
        end else begin
            state <= next_state;
            skip  <= next_skip;
            if (rx_valid_i || state == ST_IDLE || timeout) timer <= '0;
            else                                           timer <= timer + 1'b1;
        end
    end

    // Sticky status flags; a setting event in the clearing cycle wins.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            overflow_o <= 1'b0;
            kbd_err_o  <= 1'b0;
            bat_ok_o   <= 1'b0;
        end else begin
            overflow_o <= (overflow_o && !clr_status_i) || drop;
            kbd_err_o  <= (kbd_err_o  && !clr_status_i) || set_err;
            bat_ok_o   <= (bat_ok_o   && !clr_status_i) || set_bat;
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .data_i    (push_evt),
        .pop_i     (evt_ready_i),
        .data_o    (fifo_out),
        .valid_o   (evt_valid_o),
        .full_o    (fifo_full)
    );

    assign evt_o = key_event_t'(fifo_out);

endmodule
